// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the instruction/data memory port arbiter:
//   state_e : arbiter FSM states (IDLE, BUSY_D, BUSY_I)
//   WAIT_W  : width of the access wait counter (WAIT_CYC up to 15)
//   port_e  : port-select encoding used by the round-robin pointer
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Down-counter that times one memory access. Loaded with WAIT_CYC-1 when an
// access issues; decrements once per cycle and holds at zero.
// Ports:
//   clk  : clock (negedge active, like the pipeline registers)
//   rst  : synchronous active-high reset
//   load : access issues this cycle; reload the counter
//   done : counter is zero (last busy cycle when the arbiter is busy)
// -----------------------------------------------------------------------------
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam logic [WAIT_W-1:0] LOAD_VAL = WAIT_W'(WAIT_CYC - 1);

  logic [WAIT_W-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(negedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch (if_*) and the
// MEM stage (dm_*). Each access is latched at issue, held for WAIT_CYC busy
// cycles, then completes with a one-cycle valid pulse on the owning port.
// All registers update on the falling clock edge.
//
// Build option: MEM_ARB_FAIR_EN -- when defined, ties are broken by a
// round-robin pointer; otherwise data strictly beats fetch.
//
// Ports:
//   clk, rst                          : clock (negedge), sync active-high reset
//   if_req/if_addr -> if_rdata/if_valid : fetch port
//   dm_req/dm_we/dm_addr/dm_wdata
//                 -> dm_rdata/dm_valid  : data port
//   mem_en/mem_we/mem_addr/mem_wdata
//                 <- mem_rdata          : memory side
//   pipe_stall                          : freeze pipeline while a port waits
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  state_e state, state_next;
  logic   d_ok, i_ok, pick_d;
  logic   issue_d, issue_i;
  logic   done;
  logic   we_q;

`ifdef MEM_ARB_FAIR_EN
  port_e ptr;

  // After any grant the pointer names the other port.
  always_ff @(negedge clk) begin
    if (rst) begin
      ptr <= PORT_D;
    end else if (issue_d) begin
      ptr <= PORT_I;
    end else if (issue_i) begin
      ptr <= PORT_D;
    end
  end
`endif

  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    // A port is masked in its own valid cycle: its requester has not yet
    // had the chance to drop req for the access just completed.
    d_ok       = dm_req & ~dm_valid;
    i_ok       = if_req & ~if_valid;
`ifdef MEM_ARB_FAIR_EN
    pick_d     = d_ok & (~i_ok | (ptr == PORT_D));
`else
    pick_d     = d_ok;
`endif
    state_next = state;
    issue_d    = 1'b0;
    issue_i    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          issue_d    = 1'b1;
          state_next = BUSY_D;
        end else if (i_ok) begin
          issue_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_wait_timer #(
    .WAIT_CYC (WAIT_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (issue_d | issue_i),
    .done (done)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      // Latch the request at issue so requester changes during BUSY are ignored.
      if (issue_d) begin
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        we_q      <= dm_we;
      end else if (issue_i) begin
        mem_addr  <= if_addr;
        we_q      <= 1'b0;
      end

      if (state == BUSY_D && done) begin
        dm_valid <= 1'b1;
        if (!we_q) dm_rdata <= mem_rdata;  // a store leaves dm_rdata untouched
      end
      if (state == BUSY_I && done) begin
        if_valid <= 1'b1;
        if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en     = (state != IDLE);
  assign mem_we     = we_q & (state == BUSY_D);
  assign pipe_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Two arbiters side by side (WAIT_CYC=1 as instance 0, WAIT_CYC=3 as
// instance 1), each with its own request stimulus. A transaction-level
// reference model tracks the expected outputs of both every cycle; directed
// steps add fixed-value checks for the interesting scenarios, then a random
// phase exercises both instances with legal requester behaviour.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_req    [2];
  logic [7:0]  if_addr   [2];
  logic [15:0] if_rdata  [2];
  logic        if_valid  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [7:0]  dm_addr   [2];
  logic [15:0] dm_wdata  [2];
  logic [15:0] dm_rdata  [2];
  logic        dm_valid  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [7:0]  mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic        pipe_stall[2];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W   (8),
      .DATA_W   (16),
      .WAIT_CYC ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req[g]),
      .if_addr    (if_addr[g]),
      .if_rdata   (if_rdata[g]),
      .if_valid   (if_valid[g]),
      .dm_req     (dm_req[g]),
      .dm_we      (dm_we[g]),
      .dm_addr    (dm_addr[g]),
      .dm_wdata   (dm_wdata[g]),
      .dm_rdata   (dm_rdata[g]),
      .dm_valid   (dm_valid[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .pipe_stall (pipe_stall[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one in-flight access, counted in remaining busy cycles.
  typedef struct {
    int          left;    // busy cycles still to run (0 = free)
    bit          port_d;  // owner of the in-flight access
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] if_rd;
    logic [15:0] dm_rd;
    bit          if_v;
    bit          dm_v;
    bit          ptr_d;   // round-robin favours data
  } mdl_t;

  mdl_t m[2];

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.left = 0; n.port_d = 0; n.we = 0; n.addr = '0; n.wdata = '0;
    n.if_rd = '0; n.dm_rd = '0; n.if_v = 0; n.dm_v = 0; n.ptr_d = 1;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int w, bit r, bit ireq,
                                    logic [7:0] iaddr, bit dreq, bit dwe,
                                    logic [7:0] daddr, logic [15:0] dwdata,
                                    logic [15:0] rdata);
    mdl_t n = s;
    bit   d_ok, i_ok, take_d;
    if (r) return mdl_reset();
    n.if_v = 0;
    n.dm_v = 0;
    if (s.left > 0) begin
      if (s.left == 1) begin
        n.left = 0;
        if (s.port_d) begin
          n.dm_v = 1;
          if (!s.we) n.dm_rd = rdata;
        end else begin
          n.if_v  = 1;
          n.if_rd = rdata;
        end
      end else begin
        n.left = s.left - 1;
      end
    end else begin
      d_ok   = dreq && !s.dm_v;
      i_ok   = ireq && !s.if_v;
      take_d = d_ok && (!i_ok || !FAIR || s.ptr_d);
      if (take_d) begin
        n.left = w; n.port_d = 1; n.we = dwe; n.addr = daddr; n.wdata = dwdata;
        n.ptr_d = 0;
      end else if (i_ok) begin
        n.left = w; n.port_d = 0; n.we = 0; n.addr = iaddr;
        n.ptr_d = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model at the active (falling) edge, then compare
  // every output of both instances half a period later.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      m[k] = mdl_step(m[k], (k == 0) ? 1 : 3, rst, if_req[k], if_addr[k],
                      dm_req[k], dm_we[k], dm_addr[k], dm_wdata[k], mem_rdata[k]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mem_en%0d", k),    mem_en[k],    m[k].left > 0);
      check($sformatf("mem_we%0d", k),    mem_we[k],    (m[k].left > 0) && m[k].port_d && m[k].we);
      check($sformatf("mem_addr%0d", k),  mem_addr[k],  m[k].addr);
      check($sformatf("mem_wdata%0d", k), mem_wdata[k], m[k].wdata);
      check($sformatf("if_rdata%0d", k),  if_rdata[k],  m[k].if_rd);
      check($sformatf("dm_rdata%0d", k),  dm_rdata[k],  m[k].dm_rd);
      check($sformatf("if_valid%0d", k),  if_valid[k],  m[k].if_v);
      check($sformatf("dm_valid%0d", k),  dm_valid[k],  m[k].dm_v);
      check($sformatf("stall%0d", k),     pipe_stall[k],
            (if_req[k] && !m[k].if_v) || (dm_req[k] && !m[k].dm_v));
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; dm_req[k] = 0; dm_we[k] = 0;
      dm_addr[k] = '0; dm_wdata[k] = '0; mem_rdata[k] = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0;
      dm_req[k] = 0;
    end
    repeat (n) tick();
  endtask

  initial begin
    m[0] = mdl_reset();
    m[1] = mdl_reset();
    clear_inputs();

    // Reset held two cycles with both requests high everywhere.
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1; if_addr[k] = 8'h33; dm_req[k] = 1; dm_addr[k] = 8'h55;
    end
    tick();
    tick();
    check("rst_mem_en", mem_en[0], 1'b0);
    check("rst_if_valid", if_valid[1], 1'b0);
    rst = 0;
    tick();
    check("first_grant_data", mem_addr[0], 8'h55);
    check("first_grant_data_w3", mem_addr[1], 8'h55);
    idle(6);

    // Single fetch, WAIT_CYC=1.
    if_req[0] = 1; if_addr[0] = 8'h04; mem_rdata[0] = 16'h1A2B;
    tick();
    check("fetch_mem_en", mem_en[0], 1'b1);
    check("fetch_mem_addr", mem_addr[0], 8'h04);
    tick();
    check("fetch_valid", if_valid[0], 1'b1);
    check("fetch_rdata", if_rdata[0], 16'h1A2B);
    check("fetch_mem_en_off", mem_en[0], 1'b0);
    idle(2);

    // Contention: store and fetch requested together.
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 8'h10; dm_wdata[0] = 16'hBEEF;
    if_req[0] = 1; if_addr[0] = 8'h20;
    tick();
    check("cont_mem_we", mem_we[0], 1'b1);
    check("cont_mem_wdata", mem_wdata[0], 16'hBEEF);
    check("cont_mem_addr", mem_addr[0], 8'h10);
    dm_addr[0] = 8'h99;  // ignored while busy
    tick();
    check("cont_dm_valid", dm_valid[0], 1'b1);
    check("cont_stall_dv", pipe_stall[0], 1'b1);
    dm_req[0] = 0; dm_we[0] = 0;
    tick();
    check("cont_fetch_addr", mem_addr[0], 8'h20);
    check("cont_fetch_we", mem_we[0], 1'b0);
    check("cont_stall_busy", pipe_stall[0], 1'b1);
    tick();
    check("cont_if_valid", if_valid[0], 1'b1);
    check("cont_stall_iv", pipe_stall[0], 1'b0);
    idle(2);

    // Wait states, WAIT_CYC=3 load; read data sampled in the third busy cycle.
    dm_req[1] = 1; dm_we[1] = 0; dm_addr[1] = 8'h40; mem_rdata[1] = 16'h1111;
    tick();
    check("ws_en1", mem_en[1], 1'b1);
    mem_rdata[1] = 16'hA001;
    tick();
    check("ws_en2", mem_en[1], 1'b1);
    mem_rdata[1] = 16'hA002;
    tick();
    check("ws_en3", mem_en[1], 1'b1);
    check("ws_no_valid", dm_valid[1], 1'b0);
    mem_rdata[1] = 16'hA003;
    tick();
    check("ws_en_off", mem_en[1], 1'b0);
    check("ws_dm_valid", dm_valid[1], 1'b1);
    check("ws_dm_rdata", dm_rdata[1], 16'hA003);
    idle(2);

    // Reset in BUSY_D cycle 2 of 3 abandons the access.
    dm_req[1] = 1; dm_addr[1] = 8'h41; mem_rdata[1] = 16'h5555;
    tick();
    tick();
    check("rma_busy2", mem_en[1], 1'b1);
    rst = 1; dm_req[1] = 0;
    tick();
    check("rma_en_off", mem_en[1], 1'b0);
    check("rma_no_valid", dm_valid[1], 1'b0);
    rst = 0;
    tick();
    check("rma_still_no_valid", dm_valid[1], 1'b0);
    check("rma_idle", mem_en[1], 1'b0);
    idle(2);

    // Data request held continuously with a fetch pending: the data port is
    // masked in its valid cycle, which lets the fetch in right after.
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 8'h70;
    if_req[0] = 1; if_addr[0] = 8'h08;
    tick();
    check("fair_first_d", mem_addr[0], 8'h70);
    tick();
    check("fair_dm_valid", dm_valid[0], 1'b1);
    tick();
    check("fair_fetch_grant", mem_addr[0], 8'h08);
    tick();
    check("fair_if_valid", if_valid[0], 1'b1);
    if_req[0] = 0;
    tick();
    check("fair_data_again", mem_addr[0], 8'h70);
    idle(6);

    // Random phase: legal requesters (hold req until valid), random payloads,
    // occasional request drops and resets.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 2; k++) begin
        if (m[k].if_v)   if_req[k] = $urandom_range(0, 1);
        else if (!if_req[k]) if_req[k] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 31) == 0) if_req[k] = 0;
        if (m[k].dm_v)   dm_req[k] = $urandom_range(0, 1);
        else if (!dm_req[k]) dm_req[k] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 31) == 0) dm_req[k] = 0;
        if_addr[k]   = 8'($urandom);
        dm_addr[k]   = 8'($urandom);
        dm_wdata[k]  = 16'($urandom);
        dm_we[k]     = $urandom_range(0, 1);
        mem_rdata[k] = 16'($urandom);
      end
      tick();
    end

    rst = 0;
    idle(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
